// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared codes and snapshot layout for the display scanner.
// Revision : 1.0
// ============================================================================
package disp_pkg;

    localparam logic [5:0] C_MODE_CLOCK = 6'd1;
    localparam logic [5:0] C_MODE_DATE  = 6'd2;
    localparam logic [5:0] C_MODE_ALARM = 6'd3;

    localparam logic [3:0] C_BLANK = 4'd11;

    localparam logic [1:0] C_FIELD_HY   = 2'd0;
    localparam logic [1:0] C_FIELD_MM   = 2'd1;
    localparam logic [1:0] C_FIELD_SD   = 2'd2;
    localparam logic [1:0] C_FIELD_NONE = 2'd3;

    typedef struct packed {
        logic [5:0]  mode;
        logic        alarm_mode;
        logic        edit_en;
        logic [1:0]  edit_field;
        logic [15:0] year;
        logic [5:0]  month;
        logic [10:0] day;
        logic [10:0] hour;
        logic [10:0] minute;
        logic [10:0] second;
        logic [10:0] al_hour;
        logic [10:0] al_minute;
        logic [10:0] al_second;
    } snap_t;

    typedef struct packed {
        logic [3:0] thou;
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } dec4_t;

endpackage
`default_nettype wire

// File: rtl/digit_split.sv
`default_nettype none
// ============================================================================
// Module   : digit_split
// Brief    : Binary value to four decimal digits of (value mod 10000).
// Revision : 1.0
// ============================================================================
module digit_split
    import disp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] value_i,
    output dec4_t        digits_o
);

    logic [31:0] w_mod;

    assign w_mod          = 32'(value_i) % 32'd10000;
    assign digits_o.thou  = 4'(w_mod / 32'd1000);
    assign digits_o.hund  = 4'((w_mod / 32'd100) % 32'd10);
    assign digits_o.tens  = 4'((w_mod / 32'd10) % 32'd10);
    assign digits_o.ones  = 4'(w_mod % 32'd10);

endmodule
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan
// Brief    : Multiplexed digit scanner for clock/date/alarm with edit blink.
// Revision : 1.0
// ============================================================================
module disp_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250,
    parameter int NUM_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  mode,
    input  logic                        alarm_mode,
    input  logic [15:0]                 year,
    input  logic [5:0]                  month,
    input  logic [10:0]                 day,
    input  logic [10:0]                 hour,
    input  logic [10:0]                 minute,
    input  logic [10:0]                 second,
    input  logic [10:0]                 al_hour,
    input  logic [10:0]                 al_minute,
    input  logic [10:0]                 al_second,
    input  logic                        edit_en,
    input  logic [1:0]                  edit_field,
    output logic [$clog2(N_DIGITS)-1:0] light,
    output logic [N_DIGITS-1:0]         digit_en,
    output logic [NUM_W-1:0]            num
);

    localparam int LW = $clog2(N_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]       presc_q, presc_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic                first_q, first_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    snap_t               snap_q, w_snap_d;
    logic [LW-1:0]       light_q, light_d;
    logic [N_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [NUM_W-1:0]    num_q, num_d;

    logic       w_tick;
    logic       w_load;
    logic       w_time_mode;
    logic       w_use_alarm;
    snap_t      w_live;
    dec4_t      w_dh, w_dm, w_ds, w_dy, w_dmo, w_dd;
    logic [3:0] w_code;
    logic [1:0] w_field;
    int         w_pos;
    logic       w_unused;

    assign w_tick = (presc_q == PW'(SCAN_DIV - 1));
    assign w_load = w_tick && (first_q || (idx_q == LW'(N_DIGITS - 1)));

    always_comb begin
        w_live            = '0;
        w_live.mode       = mode;
        w_live.alarm_mode = alarm_mode;
        w_live.edit_en    = edit_en;
        w_live.edit_field = edit_field;
        w_live.year       = year;
        w_live.month      = month;
        w_live.day        = day;
        w_live.hour       = hour;
        w_live.minute     = minute;
        w_live.second     = second;
        w_live.al_hour    = al_hour;
        w_live.al_minute  = al_minute;
        w_live.al_second  = al_second;
    end

    // The frame-start tick both loads the snapshot and displays digit 0 from it.
    assign w_snap_d    = w_load ? w_live : snap_q;
    assign w_use_alarm = (w_snap_d.mode == C_MODE_ALARM) && w_snap_d.alarm_mode;
    assign w_time_mode = (w_snap_d.mode == C_MODE_CLOCK) || (w_snap_d.mode == C_MODE_ALARM);

    digit_split #(.W(11)) u_split_hour (
        .value_i  (w_use_alarm ? w_snap_d.al_hour : w_snap_d.hour),
        .digits_o (w_dh)
    );
    digit_split #(.W(11)) u_split_minute (
        .value_i  (w_use_alarm ? w_snap_d.al_minute : w_snap_d.minute),
        .digits_o (w_dm)
    );
    digit_split #(.W(11)) u_split_second (
        .value_i  (w_use_alarm ? w_snap_d.al_second : w_snap_d.second),
        .digits_o (w_ds)
    );
    digit_split #(.W(16)) u_split_year (
        .value_i  (w_snap_d.year),
        .digits_o (w_dy)
    );
    digit_split #(.W(6)) u_split_month (
        .value_i  (w_snap_d.month),
        .digits_o (w_dmo)
    );
    digit_split #(.W(11)) u_split_day (
        .value_i  (w_snap_d.day),
        .digits_o (w_dd)
    );

    assign w_unused = ^{w_dh.thou, w_dh.hund, w_dm.thou, w_dm.hund, w_ds.thou, w_ds.hund,
                        w_dmo.thou, w_dmo.hund, w_dd.thou, w_dd.hund};

    always_comb begin
        presc_d     = w_tick ? '0 : presc_q + PW'(1);
        idx_d       = idx_q;
        first_d     = first_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (w_tick) begin
            first_d = 1'b0;
            idx_d   = w_load ? '0 : idx_q + LW'(1);
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        w_pos   = int'(idx_d);
        w_code  = C_BLANK;
        w_field = C_FIELD_NONE;
        if (w_time_mode) begin
            case (w_pos)
                0:       begin w_code = w_dh.tens; w_field = C_FIELD_HY; end
                1:       begin w_code = w_dh.ones; w_field = C_FIELD_HY; end
                2:       begin w_code = w_dm.tens; w_field = C_FIELD_MM; end
                3:       begin w_code = w_dm.ones; w_field = C_FIELD_MM; end
                4:       begin w_code = w_ds.tens; w_field = C_FIELD_SD; end
                5:       begin w_code = w_ds.ones; w_field = C_FIELD_SD; end
                default: ;
            endcase
        end else if (w_snap_d.mode == C_MODE_DATE) begin
            case (w_pos)
                0:       begin w_code = w_dy.thou;  w_field = C_FIELD_HY; end
                1:       begin w_code = w_dy.hund;  w_field = C_FIELD_HY; end
                2:       begin w_code = w_dy.tens;  w_field = C_FIELD_HY; end
                3:       begin w_code = w_dy.ones;  w_field = C_FIELD_HY; end
                4:       begin w_code = w_dmo.tens; w_field = C_FIELD_MM; end
                5:       begin w_code = w_dmo.ones; w_field = C_FIELD_MM; end
                6:       begin w_code = w_dd.tens;  w_field = C_FIELD_SD; end
                7:       begin w_code = w_dd.ones;  w_field = C_FIELD_SD; end
                default: ;
            endcase
        end
        // Blink uses the phase in force before this tick's toggle.
        if (w_snap_d.edit_en && (w_snap_d.edit_field != C_FIELD_NONE) && phase_q &&
            (w_field == w_snap_d.edit_field)) begin
            w_code = C_BLANK;
        end
    end

    always_comb begin
        light_d    = light_q;
        digit_en_d = digit_en_q;
        num_d      = num_q;
        if (w_tick) begin
            light_d    = idx_d;
            digit_en_d = N_DIGITS'(1) << idx_d;
            num_d      = NUM_W'(w_code);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            snap_q      <= '0;
            light_q     <= '0;
            digit_en_q  <= '0;
            num_q       <= NUM_W'(C_BLANK);
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            snap_q      <= w_snap_d;
            light_q     <= light_d;
            digit_en_q  <= digit_en_d;
            num_q       <= num_d;
        end
    end

    assign light    = light_q;
    assign digit_en = digit_en_q;
    assign num      = num_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan
// Brief    : Self-checking bench for disp_scan with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_disp_scan;
    import disp_pkg::*;

    localparam int N  = 8;
    localparam int SD = 4;
    localparam int BD = 2;

    typedef int frame_t [8];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  mode;
    logic        alarm_mode;
    logic [15:0] year;
    logic [5:0]  month;
    logic [10:0] day, hour, minute, second, al_hour, al_minute, al_second;
    logic        edit_en;
    logic [1:0]  edit_field;
    logic [2:0]  light;
    logic [7:0]  digit_en;
    logic [3:0]  num;

    int errors = 0;
    int checks = 0;

    disp_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD), .NUM_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .alarm_mode(alarm_mode),
        .year(year), .month(month), .day(day),
        .hour(hour), .minute(minute), .second(second),
        .al_hour(al_hour), .al_minute(al_minute), .al_second(al_second),
        .edit_en(edit_en), .edit_field(edit_field),
        .light(light), .digit_en(digit_en), .num(num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: cycles since reset give the tick number, the tick
    // number gives the digit position, blink phase and snapshot moments.
    bit m_valid = 0;
    int cyc, ticks;
    int exp_light, exp_en, exp_num;
    int s_mode, s_alarm, s_ee, s_ef, s_y, s_mo, s_d, s_h, s_m, s_s, s_ah, s_am, s_as;

    function automatic int model_digit(input int pos, input int ph);
        int dig[8];
        int grp[8];
        int h, m, s;
        for (int i = 0; i < 8; i++) begin
            dig[i] = 11;
            grp[i] = 3;
        end
        if (s_mode == 1 || s_mode == 3) begin
            h = (s_mode == 3 && s_alarm == 1) ? s_ah : s_h;
            m = (s_mode == 3 && s_alarm == 1) ? s_am : s_m;
            s = (s_mode == 3 && s_alarm == 1) ? s_as : s_s;
            dig[0] = (h % 100) / 10; dig[1] = h % 10;
            dig[2] = (m % 100) / 10; dig[3] = m % 10;
            dig[4] = (s % 100) / 10; dig[5] = s % 10;
            for (int i = 0; i < 6; i++) grp[i] = i / 2;
        end else if (s_mode == 2) begin
            dig[0] = (s_y % 10000) / 1000;
            dig[1] = (s_y % 1000) / 100;
            dig[2] = (s_y % 100) / 10;
            dig[3] = s_y % 10;
            dig[4] = (s_mo % 100) / 10; dig[5] = s_mo % 10;
            dig[6] = (s_d % 100) / 10;  dig[7] = s_d % 10;
            grp[0] = 0; grp[1] = 0; grp[2] = 0; grp[3] = 0;
            grp[4] = 1; grp[5] = 1; grp[6] = 2; grp[7] = 2;
        end
        if (s_ee == 1 && s_ef != 3 && ph == 1 && grp[pos] == s_ef) return 11;
        return dig[pos];
    endfunction

    always @(posedge clk) begin
        int pos, ph;
        if (!rst_n) begin
            m_valid = 1; cyc = 0; ticks = 0;
            exp_light = 0; exp_en = 0; exp_num = 11;
        end else if (m_valid) begin
            cyc++;
            if (cyc % SD == 0) begin
                pos = ticks % N;
                ph  = (ticks / BD) % 2;
                if (pos == 0) begin
                    s_mode = int'(mode); s_alarm = int'(alarm_mode);
                    s_ee = int'(edit_en); s_ef = int'(edit_field);
                    s_y = int'(year); s_mo = int'(month); s_d = int'(day);
                    s_h = int'(hour); s_m = int'(minute); s_s = int'(second);
                    s_ah = int'(al_hour); s_am = int'(al_minute); s_as = int'(al_second);
                end
                exp_light = pos;
                exp_en    = 1 << pos;
                exp_num   = model_digit(pos, ph);
                ticks++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_light", int'(light), exp_light);
            chk("model_digit_en", int'(digit_en), exp_en);
            chk("model_num", int'(num), exp_num);
        end
    end

    task automatic wait_frame(output bit ok);
        logic [7:0] prev;
        prev = digit_en;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (digit_en == 8'h01 && prev != 8'h01) ok = 1;
            prev = digit_en;
        end
        if (!ok) chk("frame_start_timeout", 0, 1);
    endtask

    task automatic check_frame(input string nm, input frame_t e, input int poke_at);
        bit ok;
        wait_frame(ok);
        if (ok) begin
            chk($sformatf("%s[0]", nm), int'(num), e[0]);
            for (int j = 1; j < N; j++) begin
                repeat (SD) @(negedge clk);
                if (j == poke_at) begin
                    hour = 11'd23;
                    al_minute = 11'd6;
                end
                chk($sformatf("%s_light%0d", nm, j), int'(light), j);
                chk($sformatf("%s[%0d]", nm, j), int'(num), e[j]);
            end
        end
    endtask

    // Called right after rst_n is released at a falling edge.
    task automatic first_frame(input string nm, input frame_t e);
        for (int c = 1; c < SD; c++) begin
            @(negedge clk);
            chk($sformatf("%s_pre_en%0d", nm, c), int'(digit_en), 0);
            chk($sformatf("%s_pre_num%0d", nm, c), int'(num), 11);
        end
        @(negedge clk);
        chk($sformatf("%s_first_light", nm), int'(light), 0);
        chk($sformatf("%s_first_en", nm), int'(digit_en), 1);
        chk($sformatf("%s[0]", nm), int'(num), e[0]);
        for (int j = 1; j < N; j++) begin
            repeat (SD) @(negedge clk);
            chk($sformatf("%s_light%0d", nm, j), int'(light), j);
            chk($sformatf("%s_en%0d", nm, j), int'(digit_en), 1 << j);
            chk($sformatf("%s[%0d]", nm, j), int'(num), e[j]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; mode = 6'd1; alarm_mode = 1'b0;
        year = 16'd0; month = 6'd0; day = 11'd0;
        hour = 11'd12; minute = 11'd34; second = 11'd56;
        al_hour = 11'd0; al_minute = 11'd0; al_second = 11'd0;
        edit_en = 1'b0; edit_field = 2'd3;
        repeat (3) @(negedge clk);
        chk("reset_light", int'(light), 0);
        chk("reset_en", int'(digit_en), 0);
        chk("reset_num", int'(num), 11);
        rst_n = 1'b1;
        first_frame("clock", '{1, 2, 3, 4, 5, 6, 11, 11});

        mode = 6'd2; year = 16'd2024; month = 6'd7; day = 11'd9;
        check_frame("date", '{2, 0, 2, 4, 0, 7, 0, 9}, -1);
        year = 16'd65535; month = 6'd63; day = 11'd2047;
        check_frame("date_max", '{5, 5, 3, 5, 6, 3, 4, 7}, -1);

        mode = 6'd3; alarm_mode = 1'b1;
        al_hour = 11'd7; al_minute = 11'd5; al_second = 11'd0;
        check_frame("alarm", '{0, 7, 0, 5, 0, 0, 11, 11}, 3);
        check_frame("alarm_next", '{0, 7, 0, 6, 0, 0, 11, 11}, -1);
        alarm_mode = 1'b0;
        check_frame("alarm_clk", '{2, 3, 3, 4, 5, 6, 11, 11}, -1);

        mode = 6'd1; hour = 11'd10; minute = 11'd20; second = 11'd30;
        edit_en = 1'b1; edit_field = 2'd1;
        check_frame("edit_min", '{1, 0, 11, 11, 3, 0, 11, 11}, -1);
        edit_field = 2'd0;
        check_frame("edit_hour", '{1, 0, 2, 0, 3, 0, 11, 11}, -1);
        edit_field = 2'd3;
        check_frame("edit_none", '{1, 0, 2, 0, 3, 0, 11, 11}, -1);
        mode = 6'd2; year = 16'd2024; month = 6'd7; day = 11'd9; edit_field = 2'd0;
        check_frame("edit_year", '{2, 0, 11, 11, 0, 7, 0, 9}, -1);
        edit_en = 1'b0;

        mode = 6'd1; hour = 11'd125;
        check_frame("hour125", '{2, 5, 2, 0, 3, 0, 11, 11}, -1);
        mode = 6'd6;
        check_frame("blank_mode", '{11, 11, 11, 11, 11, 11, 11, 11}, -1);

        mode = 6'd1;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (light == 3'd4 && digit_en == 8'h10) seen = 1;
        end
        if (!seen) chk("light4_timeout", 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_light", int'(light), 0);
        chk("midreset_en", int'(digit_en), 0);
        chk("midreset_num", int'(num), 11);
        rst_n = 1'b1;
        first_frame("after_reset", '{2, 5, 2, 0, 3, 0, 11, 11});

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
